uart_echo_checker: RTL

Host-side exerciser for the UART echo test image: drives a byte pattern out over a serial line, receives the echoed stream, and checks that every returned byte equals the sent byte plus one, modulo 256. It is the peer of the on-target "receive, add one, retransmit" loopback. It sits in the tester FPGA, with its `txd`/`rxd` wired crossed to the device under test. Results are reported through status counters and a done/pass flag pair.

---
 rtl/uart_test_pkg.sv | 20 ++
 rtl/uart_echo_checker_if.sv | 26 ++
 rtl/rst_sync.sv | 18 +
 rtl/uart.sv | 97 +++++++++
 rtl/uart_echo_checker.sv | 135 +++++++++++++
 5 files changed

// File: rtl/uart_test_pkg.sv
// Shared types and constants for the UART echo exerciser.
// Holds the checker state encoding and the saturating counter helper.
package uart_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } chk_state_t;

    localparam int CNT_W = 16;
    localparam logic [7:0] ECHO_INC = 8'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_echo_checker_if.sv
// Control, status and serial pins of the echo checker grouped as one bundle.
// slave is the checker side, master is whoever drives start and the echo line.
interface uart_echo_checker_if;
    import uart_test_pkg::*;

    logic             start;
    logic             rxd;
    logic             txd;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] timeout_count;
    logic [CNT_W-1:0] byte_count;

    modport master (
        output start, rxd,
        input  txd, busy, done, pass, err_count, timeout_count, byte_count
    );

    modport slave (
        input  start, rxd,
        output txd, busy, done, pass, err_count, timeout_count, byte_count
    );

endinterface

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts as soon as rst_n falls, releases two clk edges
// after rst_n rises. Output is active-high.
module rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], 1'b0};
    end

    assign rst = sync[1];

endmodule

// File: rtl/uart.sv
// 8N1 UART, one bit every CLK_HZ/BAUD clocks. tx_data_ack fires in the same
// cycle as tx_data_valid whenever the transmitter is idle; rx_data_fresh is a one-cycle pulse.
module uart #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ack,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_fresh
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] BIT_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF_BIT = DW'(DIV / 2);

    logic [8:0]    tx_sh;
    logic [3:0]    tx_left;
    logic [DW-1:0] tx_cnt;

    assign tx_data_ack = tx_data_valid && (tx_left == 4'd0);

    // tx_left counts whole bit periods still to be driven, start bit included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd     <= 1'b1;
            tx_sh   <= '1;
            tx_left <= 4'd0;
            tx_cnt  <= '0;
        end else if (tx_data_ack) begin
            txd     <= 1'b0;
            tx_sh   <= {1'b1, tx_data};
            tx_left <= 4'd10;
            tx_cnt  <= BIT_LAST;
        end else if (tx_left != 4'd0) begin
            if (tx_cnt == '0) begin
                txd     <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_left <= tx_left - 4'd1;
                tx_cnt  <= BIT_LAST;
            end else begin
                tx_cnt <= tx_cnt - DW'(1);
            end
        end
    end

    logic [1:0]    rx_meta;
    logic          rx_in;
    logic [3:0]    rx_left;
    logic [DW-1:0] rx_cnt;
    logic [7:0]    rx_sh;

    assign rx_in = rx_meta[1];

    // Samples at bit centres; a start bit that is high at its centre is a glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta       <= 2'b11;
            rx_left       <= 4'd0;
            rx_cnt        <= '0;
            rx_sh         <= '0;
            rx_data       <= '0;
            rx_data_fresh <= 1'b0;
        end else begin
            rx_meta       <= {rx_meta[0], rxd};
            rx_data_fresh <= 1'b0;
            if (rx_left == 4'd0) begin
                if (!rx_in) begin
                    rx_left <= 4'd10;
                    rx_cnt  <= HALF_BIT;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - DW'(1);
            end else begin
                rx_cnt  <= BIT_LAST;
                rx_left <= rx_left - 4'd1;
                if (rx_left == 4'd10) begin
                    if (rx_in) rx_left <= 4'd0;
                end else if (rx_left == 4'd1) begin
                    if (rx_in) begin
                        rx_data       <= rx_sh;
                        rx_data_fresh <= 1'b1;
                    end
                end else begin
                    rx_sh <= {rx_in, rx_sh[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/uart_echo_checker.sv
// Sends an incrementing byte pattern and checks each echo equals byte+1; one byte in flight,
// next byte goes out one cycle after its echo or timeout. Status is registered, visible one cycle after the event.
module uart_echo_checker
    import uart_test_pkg::*;
#(
    parameter int         CLK_HZ         = 100_000_000,
    parameter int         BAUD           = 115200,
    parameter int         NUM_BYTES      = 256,
    parameter logic [7:0] START_VAL      = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_echo_checker_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    logic             rst;
    chk_state_t       state;
    logic [7:0]       pattern;
    logic [7:0]       rx_data;
    logic [7:0]       expect_byte;
    logic             tx_data_valid;
    logic             tx_data_ack;
    logic             rx_data_fresh;
    logic [TW-1:0]    to_cnt;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] timeout_count;
    logic [CNT_W-1:0] byte_count;
    logic             busy;
    logic             done;
    logic             pass;
    logic             echo_ok;
    logic             to_hit;
    logic             last_byte;

    rst_sync u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rst   (rst)
    );

    uart #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (pattern),
        .tx_data_valid (tx_data_valid),
        .tx_data_ack   (tx_data_ack),
        .txd           (bus.txd),
        .rxd           (bus.rxd),
        .rx_data       (rx_data),
        .rx_data_fresh (rx_data_fresh)
    );

    assign expect_byte = pattern + ECHO_INC;
    assign echo_ok     = (rx_data == expect_byte);
    assign to_hit      = (to_cnt == TO_LAST);
    assign last_byte   = (byte_count == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pattern       <= START_VAL;
            tx_data_valid <= 1'b0;
            to_cnt        <= '0;
            err_count     <= '0;
            timeout_count <= '0;
            byte_count    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        err_count     <= '0;
                        timeout_count <= '0;
                        byte_count    <= '0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        pattern       <= START_VAL;
                        tx_data_valid <= 1'b1;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Nothing is outstanding here, so any received byte is stray.
                    if (rx_data_fresh) err_count <= sat_inc(err_count);
                    if (tx_data_ack) begin
                        tx_data_valid <= 1'b0;
                        to_cnt        <= '0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A byte landing on the expiry cycle still counts as an echo.
                    if (rx_data_fresh || to_hit) begin
                        if (rx_data_fresh && !echo_ok) err_count <= sat_inc(err_count);
                        if (!rx_data_fresh) timeout_count <= sat_inc(timeout_count);
                        byte_count <= byte_count + CNT_W'(1);
                        pattern    <= pattern + 8'd1;
                        if (last_byte) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && (timeout_count == '0) &&
                                     rx_data_fresh && echo_ok;
                        end else begin
                            state         <= ST_SEND;
                            tx_data_valid <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.err_count     = err_count;
    assign bus.timeout_count = timeout_count;
    assign bus.byte_count    = byte_count;

endmodule
